fetch_unit: RTL and testbench

//  Instruction-fetch stage of the 16-bit Harvard core; sits directly upstream of the decode stage.

---
 rtl/fetch_pkg.sv | 11 +
 rtl/fetch_if.sv | 30 +++
 rtl/fetch_out_buf.sv | 60 ++++++
 rtl/fetch_unit.sv | 73 +++++++
 tb/tb_fetch_unit.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch/decode constants: FSM states, opcode field position, reset PC.
package fetch_pkg;
   localparam int FETCH_ADDR_W = 16;
   localparam int FETCH_DATA_W = 16;
   localparam int FETCH_OPC_W  = 6;
   localparam int OPC_MSB      = 15;
   localparam int OPC_LSB      = 10;
   localparam logic [FETCH_ADDR_W-1:0] RESET_PC_DEF = 16'h0000;

   typedef enum logic {S_IDLE, S_WAIT} state_t;
endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bus: instruction-memory read port, redirect input and the decode handshake.
interface fetch_if
   import fetch_pkg::*;
#(
   parameter int ADDR_W = FETCH_ADDR_W,
   parameter int DATA_W = FETCH_DATA_W,
   parameter int OPC_W  = FETCH_OPC_W
) ();
   logic              fetch_en;
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_rvalid;
   logic [DATA_W-1:0] imem_rdata;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_pc;
   logic              if_valid;
   logic              if_ready;
   logic [DATA_W-1:0] if_instr;
   logic [ADDR_W-1:0] if_pc;
   logic [OPC_W-1:0]  if_opcode;

   modport master (
      input  fetch_en, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, if_ready,
      output imem_req, imem_addr, if_valid, if_instr, if_pc, if_opcode
   );
   modport slave (
      output fetch_en, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, if_ready,
      input  imem_req, imem_addr, if_valid, if_instr, if_pc, if_opcode
   );
endinterface

// File: rtl/fetch_out_buf.sv
// One-entry valid/ready register holding {instr, pc, opcode} for decode.
module fetch_out_buf
   import fetch_pkg::*;
#(
   parameter int ADDR_W = FETCH_ADDR_W,
   parameter int DATA_W = FETCH_DATA_W,
   parameter int OPC_W  = FETCH_OPC_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              flush,
   input  logic              ready,
   input  logic [DATA_W-1:0] in_instr,
   input  logic [ADDR_W-1:0] in_pc,
   output logic              valid,
   output logic [DATA_W-1:0] instr,
   output logic [ADDR_W-1:0] pc,
   output logic [OPC_W-1:0]  opcode
);
   logic              valid_q, valid_d;
   logic [DATA_W-1:0] instr_q, instr_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [OPC_W-1:0]  opc_q, opc_d;

   // A handshake in the flush cycle still completes; flush only kills what remains.
   always_comb begin
      valid_d = valid_q;
      instr_d = instr_q;
      pc_d    = pc_q;
      opc_d   = opc_q;
      if (valid_q && ready) valid_d = 1'b0;
      if (load) begin
         valid_d = 1'b1;
         instr_d = in_instr;
         pc_d    = in_pc;
         opc_d   = in_instr[DATA_W-1 -: OPC_W];
      end
      if (flush) valid_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         instr_q <= '0;
         pc_q    <= '0;
         opc_q   <= '0;
      end else begin
         valid_q <= valid_d;
         instr_q <= instr_d;
         pc_q    <= pc_d;
         opc_q   <= opc_d;
      end
   end

   assign valid  = valid_q;
   assign instr  = instr_q;
   assign pc     = pc_q;
   assign opcode = opc_q;
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps at most one imem read in flight,
// hands {instr, pc, opcode} to decode and squashes in-flight work on redirect.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int                ADDR_W   = FETCH_ADDR_W,
   parameter int                DATA_W   = FETCH_DATA_W,
   parameter int                OPC_W    = FETCH_OPC_W,
   parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
   input  logic    clk,
   input  logic    rst_n,
   fetch_if.master bus
);
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              drop_q, drop_d;
   logic              rsp, load;

   // Issue only into an empty or draining buffer so a response always has a home.
   assign bus.imem_req  = rst_n & (state_q == S_IDLE) & bus.fetch_en & ~bus.redirect_valid
                        & (~bus.if_valid | bus.if_ready);
   assign bus.imem_addr = pc_q;

   assign rsp  = (state_q == S_WAIT) & bus.imem_rvalid;
   assign load = rsp & ~drop_q & ~bus.redirect_valid;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      drop_d  = drop_q;
      case (state_q)
         S_IDLE: if (bus.imem_req) state_d = S_WAIT;
         S_WAIT: if (bus.imem_rvalid) begin
            state_d = S_IDLE;
            drop_d  = 1'b0;
         end
         default: state_d = S_IDLE;
      endcase
      if (load) pc_d = pc_q + ADDR_W'(1);
      // A redirect while the read is still in flight poisons its eventual response.
      if (bus.redirect_valid) begin
         pc_d = bus.redirect_pc;
         if (state_q == S_WAIT && !bus.imem_rvalid) drop_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         drop_q  <= drop_d;
      end
   end

   fetch_out_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .OPC_W(OPC_W)) u_buf (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .flush    (bus.redirect_valid),
      .ready    (bus.if_ready),
      .in_instr (bus.imem_rdata),
      .in_pc    (pc_q),
      .valid    (bus.if_valid),
      .instr    (bus.if_instr),
      .pc       (bus.if_pc),
      .opcode   (bus.if_opcode)
   );
endmodule

// File: tb/tb_fetch_unit.sv
// Two fetch units (RESET_PC 0000 and FFFF) driven by directed and random steps,
// checked against a transaction-level model of the fetch stream.
module tb_fetch_unit;
   import fetch_pkg::*;

   localparam logic [1:0][15:0] RPC = {16'hFFFF, 16'h0000};

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic             fetch_en = 1'b0, if_ready = 1'b0, redir_v = 1'b0;
   logic [15:0]      redir_pc = 16'h0;
   logic [1:0]       rvalid = '0;
   logic [1:0][15:0] rdata = '0;
   logic [1:0]       o_req, o_v;
   logic [1:0][15:0] o_addr, o_instr, o_pc;
   logic [1:0][5:0]  o_opc;

   for (genvar g = 0; g < 2; g++) begin : gen_dut
      fetch_if bus ();
      assign bus.fetch_en       = fetch_en;
      assign bus.imem_rvalid    = rvalid[g];
      assign bus.imem_rdata     = rdata[g];
      assign bus.redirect_valid = redir_v;
      assign bus.redirect_pc    = redir_pc;
      assign bus.if_ready       = if_ready;
      fetch_unit #(.RESET_PC(RPC[g])) dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));
      assign o_req[g]   = bus.imem_req;
      assign o_addr[g]  = bus.imem_addr;
      assign o_v[g]     = bus.if_valid;
      assign o_instr[g] = bus.if_instr;
      assign o_pc[g]    = bus.if_pc;
      assign o_opc[g]   = bus.if_opcode;
   end

   // Reference model: one in-flight read per unit plus a one-deep delivered item.
   bit          m_out[2], m_kill[2], mb_v[2], seen_req[2];
   int          m_cnt[2];
   logic [15:0] m_addr[2], m_next[2], mb_pc[2], mb_instr[2], seen_addr[2];
   bit          rv0_seen;

   int total = 0, bad = 0;
   int lat_lo = 1, lat_hi = 1, p_fe = 100, p_rdy = 100, p_redir = 0, redir_mode = 0;
   bit stale = 1'b0;

   function automatic logic [15:0] mem(logic [15:0] a);
      return (a * 16'h3B1D) ^ 16'hABCD;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      bit exp_req;
      logic [15:0] tmp;
      for (int i = 0; i < 2; i++) begin
         chk("if_valid", 32'(o_v[i]), 32'(mb_v[i]));
         if (mb_v[i]) begin
            tmp = mb_instr[i];
            chk("if_pc", 32'(o_pc[i]), 32'(mb_pc[i]));
            chk("if_instr", 32'(o_instr[i]), 32'(tmp));
            chk("if_opcode", 32'(o_opc[i]), 32'(tmp[15:10]));
         end
      end
      fetch_en = (int'($urandom_range(99)) < p_fe);
      if_ready = (int'($urandom_range(99)) < p_rdy);
      for (int i = 0; i < 2; i++) begin
         rvalid[i] = 1'b0;
         rdata[i]  = 16'h0;
         if (m_out[i]) begin
            m_cnt[i]--;
            if (m_cnt[i] <= 0) begin
               rvalid[i] = 1'b1;
               rdata[i]  = mem(m_addr[i]);
            end
         end else if (stale) begin
            rvalid[i] = 1'b1;
            rdata[i]  = 16'hDEAD;
         end
      end
      rv0_seen = rvalid[0];
      case (redir_mode)
         1:       redir_v = 1'b1;
         2:       redir_v = rvalid[0];
         default: begin
            redir_v = (int'($urandom_range(99)) < p_redir);
            if (redir_v) redir_pc = 16'($urandom);
         end
      endcase
      #1;
      for (int i = 0; i < 2; i++) begin
         exp_req = !m_out[i] && fetch_en && !redir_v && (!mb_v[i] || if_ready);
         seen_req[i]  = o_req[i];
         seen_addr[i] = o_addr[i];
         chk("imem_req", 32'(o_req[i]), 32'(exp_req));
         if (exp_req) chk("imem_addr", 32'(o_addr[i]), 32'(m_next[i]));
         if (mb_v[i] && if_ready) mb_v[i] = 1'b0;
         if (m_out[i] && rvalid[i]) begin
            m_out[i] = 1'b0;
            if (!m_kill[i] && !redir_v) begin
               mb_v[i]     = 1'b1;
               mb_pc[i]    = m_addr[i];
               mb_instr[i] = mem(m_addr[i]);
               m_next[i]   = m_addr[i] + 16'd1;
            end
         end
         if (redir_v) begin
            mb_v[i]   = 1'b0;
            m_next[i] = redir_pc;
            if (m_out[i]) m_kill[i] = 1'b1;
         end
         if (exp_req) begin
            m_out[i]  = 1'b1;
            m_kill[i] = 1'b0;
            m_addr[i] = m_next[i];
            m_cnt[i]  = int'($urandom_range(lat_hi, lat_lo));
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; fetch_en = 1'b1; rvalid = '0; redir_v = 1'b0; if_ready = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         chk("req_in_reset", 32'(o_req[i]), 32'd0);
         m_out[i] = 1'b0; m_kill[i] = 1'b0; mb_v[i] = 1'b0; m_next[i] = RPC[i];
      end
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk("req_in_reset", 32'(o_req[i]), 32'd0);
         chk("rst_valid", 32'(o_v[i]), 32'd0);
         chk("rst_instr", 32'(o_instr[i]), 32'd0);
         chk("rst_pc", 32'(o_pc[i]), 32'd0);
         chk("rst_opcode", 32'(o_opc[i]), 32'd0);
         chk("rst_addr", 32'(o_addr[i]), 32'(RPC[i]));
      end
      rst_n = 1'b1;
   endtask

   task automatic wait_req0(string tag);
      int n = 0;
      step();
      while (!seen_req[0] && n < 20) begin step(); n++; end
      chk(tag, 32'(seen_req[0]), 32'd1);
   endtask

   task automatic wait_valid0(string tag);
      int n = 0;
      while (!o_v[0] && n < 20) begin step(); n++; end
      chk(tag, 32'(o_v[0]), 32'd1);
   endtask

   initial begin
      @(negedge clk);
      do_reset();

      // Reset fetch with L=1; decode stalled.
      p_fe = 100; p_rdy = 0; lat_lo = 1; lat_hi = 1;
      step();
      chk("t1_req0", 32'(seen_req[0]), 32'd1);
      chk("t1_addr0", 32'(seen_addr[0]), 32'h0000);
      chk("t5_addr1_first", 32'(seen_addr[1]), 32'hFFFF);
      step();
      chk("t1_valid", 32'(o_v[0]), 32'd1);
      chk("t1_instr", 32'(o_instr[0]), 32'hABCD);
      chk("t1_pc", 32'(o_pc[0]), 32'h0000);
      chk("t1_opcode", 32'(o_opc[0]), 32'h2A);
      chk("t5_pc1_first", 32'(o_pc[1]), 32'hFFFF);

      // Stall, then release.
      repeat (5) begin
         step();
         chk("t2_no_req", 32'(seen_req[0]), 32'd0);
         chk("t2_hold_instr", 32'(o_instr[0]), 32'hABCD);
      end
      p_rdy = 100;
      step();
      chk("t2_release_req", 32'(seen_req[0]), 32'd1);
      chk("t2_release_addr", 32'(seen_addr[0]), 32'h0001);
      chk("t5_addr1_wrap", 32'(seen_addr[1]), 32'h0000);
      step();
      chk("t2_pc0", 32'(o_pc[0]), 32'h0001);
      chk("t5_pc1_wrap", 32'(o_pc[1]), 32'h0000);

      // Redirect one cycle into a 3-cycle read.
      lat_lo = 3; lat_hi = 3;
      wait_req0("t3_req_timeout");
      redir_pc = 16'h0040; redir_mode = 1;
      step();
      redir_mode = 0; p_redir = 0;
      wait_req0("t3_req2_timeout");
      chk("t3_addr", 32'(seen_addr[0]), 32'h0040);
      wait_valid0("t3_valid_timeout");
      chk("t3_pc", 32'(o_pc[0]), 32'h0040);

      // Redirect coinciding with the response.
      lat_lo = 2; lat_hi = 2;
      wait_req0("t4_req_timeout");
      redir_pc = 16'h1234; redir_mode = 2;
      begin
         int n = 0;
         step();
         while (!rv0_seen && n < 20) begin step(); n++; end
         chk("t4_rv_timeout", 32'(rv0_seen), 32'd1);
      end
      chk("t4_flushed", 32'(o_v[0]), 32'd0);
      redir_mode = 0;
      wait_req0("t4_req2_timeout");
      chk("t4_addr", 32'(seen_addr[0]), 32'h1234);
      wait_valid0("t4_valid_timeout");
      chk("t4_pc", 32'(o_pc[0]), 32'h1234);

      // Reset mid-read, then a stale response.
      lat_lo = 3; lat_hi = 3;
      wait_req0("t6_req_timeout");
      step();
      do_reset();
      p_fe = 0; stale = 1'b1;
      step();
      stale = 1'b0;
      chk("t6_stale_ignored", 32'(o_v[0]), 32'd0);
      p_fe = 100;
      wait_req0("t6_req2_timeout");
      chk("t6_addr", 32'(seen_addr[0]), 32'(RPC[0]));

      // Random traffic.
      lat_lo = 1; lat_hi = 4; p_fe = 80; p_rdy = 60; p_redir = 5;
      repeat (3000) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
